wb_unit: RTL
============

# wb_unit

Writeback stage that sits directly upstream of the integer and floating-point register files. It accepts completed results from the single-cycle execute path and the variable-latency load path, and arbitrates each file's single write port. Results that lose arbitration are buffered in order. The block also keeps a pending-load scoreboard that decode uses to stall on registers whose load has not yet been written.

## Interface
- Parameters:
- `FIFO_DEPTH`, default 2: number of load-result buffer entries; must be a power of two and ≥2.
- Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `exe_valid` in 1: execute result valid this cycle; always accepted, never stalled.
- `exe_dst` in 6: destination; bit 5 = 1 selects FPR, bits 4:0 select the register.
- `exe_data` in 32: execute result data.
- `exe_byte` in 1: write only the low byte.
- `mem_valid` in 1: load result valid.
- `mem_ready` out 1: load result accepted when `mem_valid && mem_ready`.
- `mem_dst`, `mem_data`, `mem_byte` in 6/32/1: load destination, data and byte flag, same encoding as the execute fields.
- `iss_valid` in 1: a load to `iss_dst` is issued this cycle; sets its pending bit.
- `iss_dst` in 6: destination of the issued load.
- `chk_reg1`, `chk_reg2` in 6: decode source registers to check.
- `busy1`, `busy2` out 1: pending bit of the corresponding checked register (combinational).
- `gpr_w_en`, `gpr_wreg`, `gpr_wdata`, `gpr_w_byte` out 1/5/32/1: registered GPR write port.
- `fpr_w_en`, `fpr_wreg`, `fpr_wdata`, `fpr_w_byte` out 1/5/32/1: registered FPR write port.

## Operation
- Arbitration is per file, each cycle:
  - If `exe_valid` targets a file, the execute result gets that file's port.
  - Otherwise the FIFO head gets the port if it targets that file.
  - An incoming load goes straight to the port only when the FIFO is empty and the port is free. Otherwise it is enqueued.
  - Load results are strictly in order: a load never bypasses an older buffered load, even one targeting the other file.
- Only one FIFO entry is dequeued per cycle. A new load may be enqueued in the same cycle as a dequeue.
- `mem_ready` is 1 when the FIFO is not full, or when it is full and the head is dequeued this cycle.
- GPR 0:
  - Writes to GPR 0 are dropped (`gpr_w_en` stays 0); they still dequeue and clear pending.
  - `iss_dst` = GPR 0 never sets a pending bit.
- Scoreboard: a 64-bit pending bitmap.
  - Set on `iss_valid`.
  - Cleared in the cycle a load result for that register is loaded into the output write register.
  - If a set and a clear hit the same register in the same cycle, set wins.
- Byte flag passes through unchanged to `*_w_byte`.
- Protocol rule upstream guarantees: decode never issues an execute write to a register whose pending bit is set. The block does not check this.
- `rst` resets as follows:
  - FIFO emptied and bitmap cleared.
  - All `*_w_en`, `*_wreg`, `*_wdata` and `*_w_byte` outputs go to 0.
  - `mem_ready` = 1, `busy1` = `busy2` = 0.
  - Inputs are ignored during reset. An in-flight load is lost; the pipeline is flushed with it.

## Timing
- Execute result presented in cycle N: `*_w_en` is high in N+1, and the register file holds the value after the edge ending N+1.
- Unblocked load: same latency as execute, 1 cycle.
- Buffered load: 1 cycle after the cycle it wins arbitration.
- `busy*` is combinational from the bitmap.
  - An `iss_valid` in cycle N shows busy from N+1.
  - Busy drops in the cycle the write port is driven.
  - The register file still returns the old value during that cycle, so decode must also wait one more cycle or use forwarding (see Configuration).
- FIFO full: `mem_ready` = 0 in the same cycle, unless the head dequeues. Pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `WB_FWD_EN` defined:
  - Adds outputs `fwd_hit1`, `fwd_hit2` (1 bit) and `fwd_data1`, `fwd_data2` (32 bit).
  - `fwd_hitK` is 1 when a write-port output in the current cycle has `w_en` = 1, matches `chk_regK` in file and index, and has `w_byte` = 0. `fwd_dataK` is that write's data.
  - Byte writes never forward.
  - If both ports match (impossible by file bit), GPR takes priority.
- `WB_FWD_EN` undefined: these ports are absent and decode stalls an extra cycle after busy drops.

## Test plan
- Execute to GPR 5, data 0xDEADBEEF, at cycle 10 → `gpr_w_en`=1, `gpr_wreg`=5, `gpr_wdata`=0xDEADBEEF at cycle 11 only.
- Execute to GPR 3 and load to GPR 7 in the same cycle → GPR 3 written at N+1 and GPR 7 at N+2; `mem_ready` stays 1.
- Execute to FPR 2 and load to GPR 4 in the same cycle → both ports active at N+1.
- Three back-to-back GPR loads under continuous GPR execute traffic → FIFO fills, `mem_ready`=0 on the third load. When execute stops, writes occur in issue order on consecutive cycles.
- `iss_valid` to FPR 9 at cycle 5, `chk_reg1`=FPR 9 → `busy1`=1 from cycle 6. Load arrives at cycle 8 → `busy1`=0 at cycle 9. With `WB_FWD_EN`, `fwd_hit1`=1 with the load data at cycle 9.
- `rst` asserted while the FIFO holds two entries and the bitmap is non-zero → next cycle all `w_en`=0, `mem_ready`=1, `busy1`=`busy2`=0.

Source files
------------

// File: rtl/wb_unit_if.sv
// wb_unit port bundle: execute/load results, issue, decode checks, RF write ports.
// Optional forwarding outputs exist only when WB_FWD_EN is defined.
interface wb_unit_if;
  logic        exe_valid;
  logic [5:0]  exe_dst;
  logic [31:0] exe_data;
  logic        exe_byte;
  logic        mem_valid;
  logic        mem_ready;
  logic [5:0]  mem_dst;
  logic [31:0] mem_data;
  logic        mem_byte;
  logic        iss_valid;
  logic [5:0]  iss_dst;
  logic [5:0]  chk_reg1;
  logic [5:0]  chk_reg2;
  logic        busy1;
  logic        busy2;
  logic        gpr_w_en;
  logic [4:0]  gpr_wreg;
  logic [31:0] gpr_wdata;
  logic        gpr_w_byte;
  logic        fpr_w_en;
  logic [4:0]  fpr_wreg;
  logic [31:0] fpr_wdata;
  logic        fpr_w_byte;
`ifdef WB_FWD_EN
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  modport slave (
`ifdef WB_FWD_EN
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  exe_valid, exe_dst, exe_data, exe_byte,
    input  mem_valid, mem_dst, mem_data, mem_byte,
    output mem_ready,
    input  iss_valid, iss_dst, chk_reg1, chk_reg2,
    output busy1, busy2,
    output gpr_w_en, gpr_wreg, gpr_wdata, gpr_w_byte,
    output fpr_w_en, fpr_wreg, fpr_wdata, fpr_w_byte
  );

  modport master (
`ifdef WB_FWD_EN
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output exe_valid, exe_dst, exe_data, exe_byte,
    output mem_valid, mem_dst, mem_data, mem_byte,
    input  mem_ready,
    output iss_valid, iss_dst, chk_reg1, chk_reg2,
    input  busy1, busy2,
    input  gpr_w_en, gpr_wreg, gpr_wdata, gpr_w_byte,
    input  fpr_w_en, fpr_wreg, fpr_wdata, fpr_w_byte
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: per-file write-port arbitration, in-order load buffer,
// pending-load scoreboard. Define WB_FWD_EN to add write-port forwarding.
module wb_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  wb_unit_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [5:0]  dst;
    logic [31:0] data;
    logic        bt;
  } ent_t;

  ent_t          fifo_q [FIFO_DEPTH];
  ent_t          fifo_d [FIFO_DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;

  logic        gpr_w_en_q, gpr_w_en_d;
  logic [4:0]  gpr_wreg_q, gpr_wreg_d;
  logic [31:0] gpr_wdata_q, gpr_wdata_d;
  logic        gpr_w_byte_q, gpr_w_byte_d;
  logic        fpr_w_en_q, fpr_w_en_d;
  logic [4:0]  fpr_wreg_q, fpr_wreg_d;
  logic [31:0] fpr_wdata_q, fpr_wdata_d;
  logic        fpr_w_byte_q, fpr_w_byte_d;

  logic empty, full, exe_g, exe_f;
  logic deq, ready, acc, direct, enq, ld_go;
  logic gpr_sel, fpr_sel;
  ent_t head, mem_ent, ld;

  // Execute owns its file's port; head or a bypassing load takes the rest
  always_comb begin
    mem_ent = '{dst: bus.mem_dst, data: bus.mem_data, bt: bus.mem_byte};
    head    = fifo_q[rptr_q];
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    exe_g   = bus.exe_valid & ~bus.exe_dst[5];
    exe_f   = bus.exe_valid & bus.exe_dst[5];
    deq     = ~empty & (head.dst[5] ? ~exe_f : ~exe_g);
    ready   = ~full | deq;
    acc     = bus.mem_valid & ready;
    direct  = acc & empty & (bus.mem_dst[5] ? ~exe_f : ~exe_g);
    enq     = acc & ~direct;
    ld_go   = deq | direct;
    ld      = deq ? head : mem_ent;
  end

  // Next values of both registered write ports; GPR 0 writes are dropped
  always_comb begin
    gpr_sel      = 1'b0;
    gpr_wreg_d   = gpr_wreg_q;
    gpr_wdata_d  = gpr_wdata_q;
    gpr_w_byte_d = gpr_w_byte_q;
    fpr_sel      = 1'b0;
    fpr_wreg_d   = fpr_wreg_q;
    fpr_wdata_d  = fpr_wdata_q;
    fpr_w_byte_d = fpr_w_byte_q;
    if (exe_g) begin
      gpr_sel      = 1'b1;
      gpr_wreg_d   = bus.exe_dst[4:0];
      gpr_wdata_d  = bus.exe_data;
      gpr_w_byte_d = bus.exe_byte;
    end else if (ld_go && !ld.dst[5]) begin
      gpr_sel      = 1'b1;
      gpr_wreg_d   = ld.dst[4:0];
      gpr_wdata_d  = ld.data;
      gpr_w_byte_d = ld.bt;
    end
    if (exe_f) begin
      fpr_sel      = 1'b1;
      fpr_wreg_d   = bus.exe_dst[4:0];
      fpr_wdata_d  = bus.exe_data;
      fpr_w_byte_d = bus.exe_byte;
    end else if (ld_go && ld.dst[5]) begin
      fpr_sel      = 1'b1;
      fpr_wreg_d   = ld.dst[4:0];
      fpr_wdata_d  = ld.data;
      fpr_w_byte_d = ld.bt;
    end
    gpr_w_en_d = gpr_sel & (gpr_wreg_d != 5'd0);
    fpr_w_en_d = fpr_sel;
  end

  // Load buffer bookkeeping and scoreboard update (issue beats clear)
  always_comb begin
    fifo_d = fifo_q;
    if (enq) fifo_d[wptr_q] = mem_ent;
    wptr_d = wptr_q + AW'(enq);
    rptr_d = rptr_q + AW'(deq);
    cnt_d  = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
    pend_d = pend_q;
    if (ld_go) pend_d[ld.dst] = 1'b0;
    if (bus.iss_valid && bus.iss_dst != 6'd0)
      pend_d[bus.iss_dst] = 1'b1;
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      gpr_w_en_q   <= 1'b0;
      gpr_wreg_q   <= '0;
      gpr_wdata_q  <= '0;
      gpr_w_byte_q <= 1'b0;
      fpr_w_en_q   <= 1'b0;
      fpr_wreg_q   <= '0;
      fpr_wdata_q  <= '0;
      fpr_w_byte_q <= 1'b0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      gpr_w_en_q   <= gpr_w_en_d;
      gpr_wreg_q   <= gpr_wreg_d;
      gpr_wdata_q  <= gpr_wdata_d;
      gpr_w_byte_q <= gpr_w_byte_d;
      fpr_w_en_q   <= fpr_w_en_d;
      fpr_wreg_q   <= fpr_wreg_d;
      fpr_wdata_q  <= fpr_wdata_d;
      fpr_w_byte_q <= fpr_w_byte_d;
    end
  end

  // Buffer storage; occupancy is tracked by the counter, so no reset
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.mem_ready  = rst | ready;
  assign bus.busy1      = ~rst & pend_q[bus.chk_reg1];
  assign bus.busy2      = ~rst & pend_q[bus.chk_reg2];
  assign bus.gpr_w_en   = gpr_w_en_q;
  assign bus.gpr_wreg   = gpr_wreg_q;
  assign bus.gpr_wdata  = gpr_wdata_q;
  assign bus.gpr_w_byte = gpr_w_byte_q;
  assign bus.fpr_w_en   = fpr_w_en_q;
  assign bus.fpr_wreg   = fpr_wreg_q;
  assign bus.fpr_wdata  = fpr_wdata_q;
  assign bus.fpr_w_byte = fpr_w_byte_q;

`ifdef WB_FWD_EN
  logic g_hit1, g_hit2, f_hit1, f_hit2;

  // Full-word writes on either port forward to matching decode sources
  always_comb begin
    g_hit1 = gpr_w_en_q & ~gpr_w_byte_q & (bus.chk_reg1 == {1'b0, gpr_wreg_q});
    g_hit2 = gpr_w_en_q & ~gpr_w_byte_q & (bus.chk_reg2 == {1'b0, gpr_wreg_q});
    f_hit1 = fpr_w_en_q & ~fpr_w_byte_q & (bus.chk_reg1 == {1'b1, fpr_wreg_q});
    f_hit2 = fpr_w_en_q & ~fpr_w_byte_q & (bus.chk_reg2 == {1'b1, fpr_wreg_q});
  end

  assign bus.fwd_hit1  = g_hit1 | f_hit1;
  assign bus.fwd_hit2  = g_hit2 | f_hit2;
  assign bus.fwd_data1 = g_hit1 ? gpr_wdata_q : f_hit1 ? fpr_wdata_q : '0;
  assign bus.fwd_data2 = g_hit2 ? gpr_wdata_q : f_hit2 ? fpr_wdata_q : '0;
`endif
endmodule
